// File: rtl/uart_tx_fifo.sv
// Purpose: small circular buffer of DBIT-wide words with registered occupancy count.
// Latency: a push is visible in count/empty/full after the write edge; pop_dat is a direct read of the head entry.
// Backpressure: pushes while full and pops while empty are ignored; the owner flags overflow.
module uart_tx_fifo_buf #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] w_ptr;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // Full/empty come straight from the registered count, so they are glitch-free flags.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign pop_dat = mem[r_ptr];

    // Storage array: contents need no reset, only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[w_ptr] <= push_dat;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                w_ptr <= w_ptr + AW'(1);
            if (pop_ok)
                r_ptr <= r_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// Purpose: buffers system bytes and launches them one at a time into a UART transmitter.
// Latency: write into an empty buffer at edge t gives tx_start after edge t+1; next launch one edge after tx_done_tick.
// Backpressure: full is raised at 2**ADDR_W words; writes while full are dropped and pulse overflow one cycle later.
module uart_tx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [DBIT-1:0] w_data,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_data,
    input  logic            tx_done_tick,
    output logic            busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            launch;
    logic [DBIT-1:0] head_dat;

    // The write decision uses the registered full flag, so a pop in the same cycle never makes room.
    uart_tx_fifo_buf #(
        .W  (DBIT),
        .AW (ADDR_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (wr),
        .push_dat (w_data),
        .pop      (launch),
        .pop_dat  (head_dat),
        .full     (full),
        .empty    (empty)
    );

    assign busy = (state == WAIT);

    // Next state: launch from IDLE whenever a word is queued, return on the transmitter's done tick.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    launch    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (tx_done_tick)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any outstanding launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Registered launch pulse, held transmit byte and overflow indication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            tx_start <= launch;
            if (launch)
                tx_data <= head_dat;
            overflow <= wr & full;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model (fixed-length frames).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_uart_tx_fifo;

    localparam int FRAME = 100;

    logic       clk;
    logic       reset;
    logic       wr;
    logic [7:0] w_data;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done_tick;
    logic       busy;

    logic       tx_done_man;
    logic       tx_done_model;
    logic       model_en;

    logic [7:0] sent_q[$];
    int         start_cnt;
    int         viol;
    int         frame_cnt;
    logic       prev_start;

    int         n_chk;
    int         n_pass;

    assign tx_done_tick = tx_done_man | tx_done_model;

    uart_tx_fifo #(
        .DBIT   (8),
        .ADDR_W (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .w_data       (w_data),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: logs every launch, checks pulse spacing, answers with done after FRAME cycles.
    initial begin
        tx_done_model = 1'b0;
        frame_cnt     = 0;
        prev_start    = 1'b0;
        start_cnt     = 0;
        viol          = 0;
        forever begin
            @(negedge clk);
            tx_done_model = 1'b0;
            if (reset) begin
                frame_cnt  = 0;
                prev_start = 1'b0;
            end else begin
                if (tx_start) begin
                    sent_q.push_back(tx_data);
                    start_cnt++;
                    if (prev_start)
                        viol++;
                    if (model_en)
                        frame_cnt = FRAME;
                end else if (frame_cnt > 0) begin
                    frame_cnt--;
                    if (frame_cnt == 0)
                        tx_done_model = 1'b1;
                end
                prev_start = tx_start;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic done_pulse();
        tx_done_man = 1'b1;
        cyc(1);
        tx_done_man = 1'b0;
    endtask

    initial begin
        logic [7:0] burst [5];
        logic [7:0] fill  [5];
        int         snap;

        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        fill  = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        n_chk       = 0;
        n_pass      = 0;
        reset       = 1'b1;
        wr          = 1'b0;
        w_data      = 8'h00;
        tx_done_man = 1'b0;
        model_en    = 1'b0;

        // Reset state and idle behaviour.
        cyc(3);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
        cyc(20);
        chk("idle_no_start", start_cnt, 0);
        chk("idle_empty", empty, 1);
        chk("idle_tx_data", tx_data, 0);
        chk("idle_busy", busy, 0);

        // Single byte: launch two edges after the write, one-cycle pulse, manual done.
        wr = 1'b1; w_data = 8'hA5;
        cyc(1);
        wr = 1'b0;
        chk("a5_start_early", tx_start, 0);
        chk("a5_not_empty", empty, 0);
        cyc(1);
        chk("a5_start", tx_start, 1);
        chk("a5_data", tx_data, 8'hA5);
        chk("a5_busy", busy, 1);
        cyc(1);
        chk("a5_pulse_width", tx_start, 0);
        chk("a5_data_held", tx_data, 8'hA5);
        cyc(47);
        done_pulse();
        chk("a5_idle", busy, 0);
        chk("a5_empty", empty, 1);
        cyc(2);
        chk("a5_single_launch", start_cnt, 1);

        // Burst of five from idle: 0x11 pops on the second write edge, so 0x55 fits and fills the buffer.
        model_en = 1'b1;
        sent_q.delete();
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; w_data = burst[i];
            cyc(1);
            chk($sformatf("burst_full_%0d", i), full, (i == 4) ? 1 : 0);
            chk($sformatf("burst_ovf_%0d", i), overflow, 0);
        end
        wr = 1'b0;
        for (int k = 0; k < 1000 && sent_q.size() < 5; k++)
            cyc(1);
        chk("burst_count", sent_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < sent_q.size())
                chk($sformatf("burst_order_%0d", i), sent_q[i], burst[i]);
        cyc(FRAME + 10);
        chk("burst_end_busy", busy, 0);
        chk("burst_end_empty", empty, 1);

        // Fill to full, then hold wr with 0xEE for three cycles: dropped, overflow each cycle.
        sent_q.delete();
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; w_data = fill[i];
            cyc(1);
        end
        chk("fill_full", full, 1);
        w_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk($sformatf("ovf_pulse_%0d", i), overflow, 1);
            chk($sformatf("ovf_full_%0d", i), full, 1);
        end
        wr = 1'b0;
        cyc(1);
        chk("ovf_clear", overflow, 0);
        for (int k = 0; k < 1000 && sent_q.size() < 5; k++)
            cyc(1);
        cyc(FRAME + 10);
        chk("fill_count_no_ee", sent_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < sent_q.size())
                chk($sformatf("fill_order_%0d", i), sent_q[i], fill[i]);
        chk("fill_end_empty", empty, 1);

        // Write on the same edge as a pop with two words queued: occupancy stays at two.
        model_en = 1'b0;
        sent_q.delete();
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; w_data = 8'h71 + 8'(i);
            cyc(1);
        end
        wr = 1'b0;
        cyc(1);
        chk("sim_pre_busy", busy, 1);
        chk("sim_pre_full", full, 0);
        done_pulse();
        wr = 1'b1; w_data = 8'h74;
        cyc(1);
        chk("sim_start", tx_start, 1);
        chk("sim_data", tx_data, 8'h72);
        w_data = 8'h75;
        cyc(1);
        chk("sim_cnt3_not_full", full, 0);
        w_data = 8'h76;
        cyc(1);
        chk("sim_cnt4_full", full, 1);
        wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            done_pulse();
            cyc(1);
            chk($sformatf("sim_drain_start_%0d", i), tx_start, 1);
            chk($sformatf("sim_drain_data_%0d", i), tx_data, 8'h73 + 8'(i));
        end
        done_pulse();
        cyc(1);
        chk("sim_end_busy", busy, 0);
        chk("sim_end_empty", empty, 1);
        chk("sim_sent_count", sent_q.size(), 6);

        // Ten words through the four-entry buffer, writing whenever there is room.
        model_en = 1'b1;
        sent_q.delete();
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 500 && full; k++)
                cyc(1);
            wr = 1'b1; w_data = 8'h80 + 8'(i);
            cyc(1);
            wr = 1'b0;
        end
        for (int k = 0; k < 2000 && sent_q.size() < 10; k++)
            cyc(1);
        chk("wrap_count", sent_q.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < sent_q.size())
                chk($sformatf("wrap_order_%0d", i), sent_q[i], 8'h80 + 8'(i));
        cyc(FRAME + 10);

        // Reset while waiting with three words queued, stray done, then normal operation.
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; w_data = 8'hA1 + 8'(i);
            cyc(1);
        end
        wr = 1'b0;
        cyc(2);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_start", tx_start, 0);
        chk("mid_rst_data", tx_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", overflow, 0);
        reset = 1'b0;
        model_en = 1'b0;
        sent_q.delete();
        snap = start_cnt;
        cyc(1);
        done_pulse();
        cyc(5);
        chk("stray_no_launch", start_cnt, snap);
        chk("stray_busy", busy, 0);
        chk("stray_empty", empty, 1);
        model_en = 1'b1;
        wr = 1'b1; w_data = 8'h5A;
        cyc(1);
        wr = 1'b0;
        cyc(1);
        chk("post_rst_start", tx_start, 1);
        chk("post_rst_data", tx_data, 8'h5A);
        cyc(FRAME + 10);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_count", sent_q.size(), 1);

        chk("start_never_consecutive", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
